// File: rtl/pipe_scroller.sv
// Pipe obstacle slots: spawn at the right edge, scroll left per divided tick, retire at x=0, score at BIRD_X.
// Outputs registered, one cycle after the tick; no backpressure. Build macro SPEEDUP_EN: step +1 per 8 points.
module pipe_scroller #(
  parameter int N          = 10,
  parameter int NUM_PIPES  = 4,
  parameter int SCREEN_W   = 640,
  parameter int PIPE_WIDTH = 20,
  parameter int BIRD_SIZE  = 15,
  parameter int BIRD_X     = 100,
  parameter int SPACING    = 200,
  parameter int TICK_DIV   = 208333,
  parameter int MAX_STEP   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   game_over,
  input  logic [9:0]             rand_in,
  output logic [NUM_PIPES-1:0]   pipe_valid,
  output logic [NUM_PIPES*N-1:0] pipe_x,
  output logic [NUM_PIPES*N-1:0] pipe_y1,
  output logic [NUM_PIPES*N-1:0] pipe_y0,
  output logic                   score_pulse,
  output logic [N-1:0]           score,
  output logic                   running
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [N-1:0]  SPAWN_X   = N'(SCREEN_W - PIPE_WIDTH);
  localparam logic [N-1:0]  SPAWN_LIM = N'(SCREEN_W - PIPE_WIDTH - SPACING);
  localparam logic [N-1:0]  BIRD_COL  = N'(BIRD_X);
  localparam logic [N-1:0]  GAP_S     = N'(2 * BIRD_SIZE);
  localparam logic [N-1:0]  GAP_L     = N'(3 * BIRD_SIZE);
  localparam logic [N-1:0]  STEP_MAX  = N'(MAX_STEP);
  localparam logic [N-1:0]  Y_TOP     = N'(16);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_PIPES-1:0] valid_q, valid_d;
  logic [N-1:0]         x_q  [NUM_PIPES];
  logic [N-1:0]         x_d  [NUM_PIPES];
  logic [N-1:0]         y1_q [NUM_PIPES];
  logic [N-1:0]         y1_d [NUM_PIPES];
  logic [N-1:0]         y0_q [NUM_PIPES];
  logic [N-1:0]         y0_d [NUM_PIPES];
  logic [N-1:0]         step_q, step_d;
  logic [N-1:0]         score_q, score_d;
  logic [IW-1:0]        last_q, last_d;
  logic                 pulse_q, pulse_d;
  logic                 running_q, running_d;
  logic                 tick;
  logic [N-1:0]         hits;
  logic                 free_found;
  logic [IW-1:0]        free_idx;
  logic                 rand_unused;

  assign rand_unused = rand_in[9];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    x_d        = x_q;
    y1_d       = y1_q;
    y0_d       = y0_q;
    step_d     = step_q;
    score_d    = score_q;
    last_d     = last_q;
    pulse_d    = 1'b0;
    hits       = '0;
    free_found = 1'b0;
    free_idx   = '0;
    tick       = (state_q == RUN) && !game_over && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (game_over) state_d = HALT;
      HALT:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);

    if (state_q == IDLE) begin
      cnt_d   = '0;
      valid_d = '0;
      step_d  = N'(1);
      score_d = '0;
      last_d  = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_d[i]  = '0;
        y1_d[i] = '0;
        y0_d[i] = '0;
      end
    end else if (state_q == RUN && !game_over) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        // Scoring looks at pre-move x so each pipe crosses the window exactly once.
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (valid_q[i]) begin
            if (x_q[i] >= BIRD_COL && x_q[i] < BIRD_COL + step_q) hits = hits + N'(1);
            if (x_q[i] < step_q) valid_d[i] = 1'b0;
            else                 x_d[i]     = x_q[i] - step_q;
          end
        end
        score_d = score_q + hits;
        pulse_d = (hits != '0);
`ifdef SPEEDUP_EN
        if (score_d[N-1:3] != score_q[N-1:3] && step_q < STEP_MAX) step_d = step_q + N'(1);
`endif
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
          if (!valid_d[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
          end
        end
        // A retired or never-used last slot imposes no spacing constraint.
        if (free_found && (!valid_d[last_q] || x_d[last_q] <= SPAWN_LIM)) begin
          valid_d[free_idx] = 1'b1;
          x_d[free_idx]     = SPAWN_X;
          y1_d[free_idx]    = Y_TOP + N'(rand_in[7:0]);
          y0_d[free_idx]    = Y_TOP + N'(rand_in[7:0]) + (rand_in[8] ? GAP_L : GAP_S);
          last_d            = free_idx;
        end
      end
    end

    if (step_d > STEP_MAX) step_d = STEP_MAX;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= '0;
      step_q    <= N'(1);
      score_q   <= '0;
      last_q    <= '0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]  <= '0;
        y1_q[i] <= '0;
        y0_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      step_q    <= step_d;
      score_q   <= score_d;
      last_q    <= last_d;
      pulse_q   <= pulse_d;
      running_q <= running_d;
      x_q       <= x_d;
      y1_q      <= y1_d;
      y0_q      <= y0_d;
    end
  end

  always_comb begin
    pipe_x  = '0;
    pipe_y1 = '0;
    pipe_y0 = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x[i*N +: N]  = x_q[i];
      pipe_y1[i*N +: N] = y1_q[i];
      pipe_y0[i*N +: N] = y0_q[i];
    end
  end

  assign pipe_valid  = valid_q;
  assign score_pulse = pulse_q;
  assign score       = score_q;
  assign running     = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: a 4-slot instance (SPACING=20) and a 2-slot instance (SPACING=0).
module tb_pipe_scroller;
  localparam int N = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, game_over;
  logic [9:0] rand_in;

  logic [3:0]   a_valid;
  logic [4*N-1:0] a_x, a_y1, a_y0;
  logic         a_pulse, a_running;
  logic [N-1:0] a_score;

  logic [1:0]   b_valid;
  logic [2*N-1:0] b_x, b_y1, b_y0;
  logic         b_pulse, b_running;
  logic [N-1:0] b_score;

  pipe_scroller #(.N(N), .NUM_PIPES(4), .SCREEN_W(64), .PIPE_WIDTH(4), .BIRD_SIZE(15),
                  .BIRD_X(10), .SPACING(20), .TICK_DIV(4), .MAX_STEP(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .game_over(game_over), .rand_in(rand_in),
    .pipe_valid(a_valid), .pipe_x(a_x), .pipe_y1(a_y1), .pipe_y0(a_y0),
    .score_pulse(a_pulse), .score(a_score), .running(a_running));

  pipe_scroller #(.N(N), .NUM_PIPES(2), .SCREEN_W(64), .PIPE_WIDTH(4), .BIRD_SIZE(15),
                  .BIRD_X(10), .SPACING(0), .TICK_DIV(4), .MAX_STEP(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .game_over(1'b0), .rand_in(rand_in),
    .pipe_valid(b_valid), .pipe_x(b_x), .pipe_y1(b_y1), .pipe_y0(b_y0),
    .score_pulse(b_pulse), .score(b_score), .running(b_running));

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
    edge_n += n;
  endtask

  // Tick k lands on edge 5+4*(k-1) after start is raised out of IDLE.
  task automatic run_to_tick(input int t);
    int target;
    target = 5 + 4 * (t - 1);
    if (target > edge_n) edges(target - edge_n);
  endtask

  function automatic int ax(input int i); return int'(a_x[i*N +: N]); endfunction
  function automatic int ay1(input int i); return int'(a_y1[i*N +: N]); endfunction
  function automatic int ay0(input int i); return int'(a_y0[i*N +: N]); endfunction
  function automatic int bx(input int i); return int'(b_x[i*N +: N]); endfunction

  initial begin
    reset = 1'b1; start = 1'b0; game_over = 1'b0; rand_in = 10'h005;
    edges(2);
    check_eq("rst_valid", a_valid, 0);
    check_eq("rst_score", a_score, 0);
    check_eq("rst_running", a_running, 0);
    check_eq("rst_pulse", a_pulse, 0);

    reset = 1'b0; start = 1'b1; edge_n = 0;
    edges(4);
    check_eq("pre_tick_valid", a_valid, 0);
    check_eq("running", a_running, 1);
    run_to_tick(1);
    check_eq("t1_valid", a_valid, 1);
    check_eq("t1_x0", ax(0), 60);
    check_eq("t1_y1", ay1(0), 21);
    check_eq("t1_y0", ay0(0), 51);
    rand_in = 10'h10A;

    run_to_tick(3);
    check_eq("b_t3_valid", b_valid, 3);
    check_eq("b_t3_x0", bx(0), 58);
    check_eq("b_t3_x1", bx(1), 59);
    check_eq("b_t3_gap", int'(b_y0[N +: N]) - int'(b_y1[N +: N]), 45);

    run_to_tick(20);
    check_eq("t20_valid", a_valid, 1);
    check_eq("t20_x0", ax(0), 41);
    run_to_tick(21);
    check_eq("t21_valid", a_valid, 3);
    check_eq("t21_x1", ax(1), 60);
    check_eq("t21_x0", ax(0), 40);
    check_eq("t21_y1", ay1(1), 26);
    check_eq("t21_y0", ay0(1), 71);

    run_to_tick(51);
    check_eq("t51_x0", ax(0), 10);
    check_eq("t51_score", a_score, 0);
    check_eq("t51_pulse", a_pulse, 0);
    run_to_tick(52);
    check_eq("t52_pulse", a_pulse, 1);
    check_eq("t52_score", a_score, 1);
    edges(1);
    check_eq("pulse_width", a_pulse, 0);
    check_eq("score_hold", a_score, 1);
    run_to_tick(53);
    check_eq("b_t53_score", b_score, 2);

    run_to_tick(61);
    check_eq("t61_valid0", a_valid[0], 1);
    check_eq("t61_x0", ax(0), 0);
    run_to_tick(62);
    check_eq("t62_valid", a_valid, 14);
    check_eq("b_t62_valid", b_valid, 3);
    check_eq("b_t62_x0", bx(0), 60);
    check_eq("b_t62_x1", bx(1), 0);

    edges(3);
    game_over = 1'b1;
    edges(1);
    check_eq("go_running", a_running, 0);
    check_eq("go_x1", ax(1), 19);
    check_eq("go_valid", a_valid, 14);
    edges(4);
    check_eq("halt_x1", ax(1), 19);
    check_eq("halt_x2", ax(2), 39);
    check_eq("halt_x3", ax(3), 59);
    start = 1'b0;
    edges(1);
    check_eq("idle_entry_valid", a_valid, 14);
    edges(1);
    check_eq("idle_valid", a_valid, 0);
    check_eq("idle_score", a_score, 0);
    check_eq("idle_x1", ax(1), 0);
    check_eq("idle_y0_bus", (a_y0 == '0) ? 1 : 0, 1);
    game_over = 1'b0;

    check_eq("b_run_start_low", b_running, 1);
    check_eq("b_score_pre_rst", b_score, 2);
    reset = 1'b1;
    edges(1);
    check_eq("b_rst_score", b_score, 0);
    check_eq("b_rst_valid", b_valid, 0);
    check_eq("b_rst_running", b_running, 0);

    rand_in = 10'h005;
    reset = 1'b0; start = 1'b1; edge_n = 0;
`ifdef SPEEDUP_EN
    run_to_tick(192);
    check_eq("sp_score8", a_score, 8);
    check_eq("sp_x3_t192", ax(3), 9);
    run_to_tick(193);
    check_eq("sp_x3_step2", ax(3), 7);
    reset = 1'b1;
    edges(1);
    check_eq("sp_rst_score", a_score, 0);
    reset = 1'b0; edge_n = 0;
`endif
    run_to_tick(2);
    check_eq("rerun_valid", a_valid, 1);
    check_eq("rerun_x0_step1", ax(0), 59);
    check_eq("rerun_score", a_score, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
